// File: rtl/dmux_pkg.sv
// dmux_pkg: shared types and defaults for the DMUX source-side launcher.
//   dmux_tx_state_e      - launcher FSM states
//   DMUX_DATA_WIDTH_DEF  - default word width (matches DMUX data_in)
//   DMUX_SYNC_STAGES_DEF - default synchronizer depth for the ack toggle
package dmux_pkg;

    localparam int DMUX_DATA_WIDTH_DEF  = 39;
    localparam int DMUX_SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        HOLD     = 2'd2,
        WAIT_ACK = 2'd3
    } dmux_tx_state_e;

endpackage

// File: rtl/dmux_tx_if.sv
// dmux_tx_if: upstream stream plus crossing-side signals of the launcher.
//   src_data/src_vld/src_rdy - upstream valid/ready word stream
//   data_out/data_out_vld    - held word and launch pulse toward DMUX data_in
//   dst_ack_tgl              - asynchronous toggle acknowledge from destination
// master: the launcher (dmux_tx); slave: the surrounding logic / bench.
interface dmux_tx_if
    import dmux_pkg::*;
#(
    parameter int DATA_WIDTH = DMUX_DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_vld;
    logic                  src_rdy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_vld;
    logic                  dst_ack_tgl;

    modport master (
        input  src_data, src_vld, dst_ack_tgl,
        output src_rdy, data_out, data_out_vld
    );

    modport slave (
        output src_data, src_vld, dst_ack_tgl,
        input  src_rdy, data_out, data_out_vld
    );
endinterface

// File: rtl/dmux_ack_sync.sv
// dmux_ack_sync: synchronizes the destination's ack toggle and flags each
// change of level as a one-cycle edge.
//   clk_i, reset_n - launcher clock, async active-low reset
//   i_ack_tgl      - asynchronous toggle input
//   o_ack_edge     - one-cycle pulse per toggle, SYNC_STAGES+1 cycles after it
module dmux_ack_sync
    import dmux_pkg::*;
#(
    parameter int SYNC_STAGES = DMUX_SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic i_ack_tgl,
    output logic o_ack_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ack_tgl};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Combinational compare so the FSM acts on the edge SYNC_STAGES+1
    // cycles after the toggle; it self-clears once r_prev catches up.
    assign o_ack_edge = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/dmux_tx.sv
// dmux_tx: source-side launcher for the DMUX crossing.
// Accepts a word from the upstream stream, presents it on data_out with a
// one-cycle data_out_vld pulse and keeps it stable for HOLD_CYCLES cycles
// (pulse cycle included). With USE_ACK=1 it then waits for the destination's
// ack toggle (or a TIMEOUT_CYCLES expiry) before accepting the next word.
//   clk_i, reset_n - clock, async active-low reset
//   bus (master)   - src_data/src_vld/src_rdy, data_out/data_out_vld, dst_ack_tgl
//   busy           - high in any state other than IDLE
//   ack_timeout    - one-cycle pulse when the ack wait expires
//   spurious_ack   - one-cycle pulse on an ack edge seen while IDLE
module dmux_tx
    import dmux_pkg::*;
#(
    parameter int DATA_WIDTH     = DMUX_DATA_WIDTH_DEF,
    parameter int HOLD_CYCLES    = 4,
    parameter int SYNC_STAGES    = DMUX_SYNC_STAGES_DEF,
    parameter bit USE_ACK        = 1'b1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic      clk_i,
    input  logic      reset_n,
    dmux_tx_if.master bus,
    output logic      busy,
    output logic      ack_timeout,
    output logic      spurious_ack
);

    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // HOLD covers cycles 2..HOLD_CYCLES of the window, counted 0..HOLD_LAST.
    localparam logic [7:0]      HOLD_LAST = 8'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    dmux_tx_state_e        r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_vld;
    logic                  r_src_rdy;
    logic                  r_busy;
    logic                  r_ack_timeout;
    logic                  r_spurious;
    logic                  r_sticky;
    logic [7:0]            r_hold_cnt;
    logic [TO_W-1:0]       r_to_cnt;

    logic w_ack_raw;
    logic w_ack_edge;

    dmux_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .i_ack_tgl  (bus.dst_ack_tgl),
        .o_ack_edge (w_ack_raw)
    );

    // Without ack handshaking the toggle is ignored entirely.
    assign w_ack_edge = USE_ACK ? w_ack_raw : 1'b0;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_data        <= '0;
            r_data_vld    <= 1'b0;
            r_src_rdy     <= 1'b0;
            r_busy        <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_spurious    <= 1'b0;
            r_sticky      <= 1'b0;
            r_hold_cnt    <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_data_vld    <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_spurious    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_spurious <= w_ack_edge;
                    r_sticky   <= 1'b0;
                    if (bus.src_vld && r_src_rdy) begin
                        r_data     <= bus.src_data;
                        r_data_vld <= 1'b1;
                        r_src_rdy  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= LAUNCH;
                    end else begin
                        r_src_rdy <= 1'b1;
                    end
                end
                LAUNCH: begin
                    // An ack arriving before WAIT_ACK must not be lost.
                    if (w_ack_edge) r_sticky <= 1'b1;
                    r_hold_cnt <= '0;
                    r_to_cnt   <= '0;
                    if (HOLD_CYCLES > 1) begin
                        r_state <= HOLD;
                    end else if (USE_ACK) begin
                        r_state <= WAIT_ACK;
                    end else begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_src_rdy <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_ack_edge) r_sticky <= 1'b1;
                    r_to_cnt <= '0;
                    if (r_hold_cnt == HOLD_LAST) begin
                        if (USE_ACK) begin
                            r_state <= WAIT_ACK;
                        end else begin
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_src_rdy <= 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                WAIT_ACK: begin
                    // Ack (live or latched) takes priority over the expiry.
                    if (w_ack_edge || r_sticky) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_src_rdy <= 1'b1;
                        r_sticky  <= 1'b0;
                    end else if ((TIMEOUT_CYCLES > 0) && (r_to_cnt == TO_LAST)) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_src_rdy     <= 1'b1;
                        r_ack_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.src_rdy      = r_src_rdy;
    assign bus.data_out     = r_data;
    assign bus.data_out_vld = r_data_vld;
    assign busy             = r_busy;
    assign ack_timeout      = r_ack_timeout;
    assign spurious_ack     = r_spurious;

endmodule

// File: tb/tb_dmux_tx.sv
// tb_dmux_tx: two launchers side by side (index 0: USE_ACK=0, index 1:
// USE_ACK=1), both HOLD_CYCLES=4, SYNC_STAGES=2, TIMEOUT_CYCLES=64. A
// cycle-level model derives every output from the launch/hold/ack rules;
// directed sequences add hand-computed timing expectations.
`timescale 1ns/1ps
module tb_dmux_tx;

    localparam int DW   = 39;
    localparam int HOLD = 4;
    localparam int SYNC = 2;
    localparam int TMO  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int to_cnt[2];
    int sp_cnt[2];

    logic [1:0]    t_vld;
    logic [1:0]    t_tgl;
    logic [DW-1:0] t_data [2];

    logic [1:0]    o_rdy, o_vld, o_busy, o_to, o_sp;
    logic [DW-1:0] o_data [2];

    dmux_tx_if #(.DATA_WIDTH(DW)) if0 ();
    dmux_tx_if #(.DATA_WIDTH(DW)) if1 ();

    assign if0.src_data    = t_data[0];
    assign if0.src_vld     = t_vld[0];
    assign if0.dst_ack_tgl = t_tgl[0];
    assign if1.src_data    = t_data[1];
    assign if1.src_vld     = t_vld[1];
    assign if1.dst_ack_tgl = t_tgl[1];
    assign o_rdy  = {if1.src_rdy, if0.src_rdy};
    assign o_vld  = {if1.data_out_vld, if0.data_out_vld};
    assign o_data[0] = if0.data_out;
    assign o_data[1] = if1.data_out;

    dmux_tx #(.DATA_WIDTH(DW), .HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC),
              .USE_ACK(1'b0), .TIMEOUT_CYCLES(TMO)) u_dut0 (
        .clk_i(clk), .reset_n(rst_n), .bus(if0),
        .busy(o_busy[0]), .ack_timeout(o_to[0]), .spurious_ack(o_sp[0]));

    dmux_tx #(.DATA_WIDTH(DW), .HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC),
              .USE_ACK(1'b1), .TIMEOUT_CYCLES(TMO)) u_dut1 (
        .clk_i(clk), .reset_n(rst_n), .bus(if1),
        .busy(o_busy[1]), .ack_timeout(o_to[1]), .spurious_ack(o_sp[1]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- behavioural model ----------------
    // m_ph = cycles elapsed since the launch pulse; window is ph 0..HOLD-1,
    // ack wait follows. Ack toggles are seen through a plain delay line:
    // the toggle is acted on SYNC_STAGES+1 edges after it is driven.
    logic          m_rdy[2], m_vld[2], m_busy[2], m_to[2], m_sp[2], m_acked[2];
    logic [DW-1:0] m_data[2];
    int            m_ph[2];
    logic [5:0]    m_h[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rdy[i] = 0; m_vld[i] = 0; m_busy[i] = 0; m_to[i] = 0; m_sp[i] = 0;
            m_acked[i] = 0; m_data[i] = '0; m_ph[i] = 0; m_h[i] = '0;
        end
    endtask

    task automatic model_step(input int i);
        logic ua, det, go_idle;
        ua = (i == 1);
        m_h[i] = {m_h[i][4:0], t_tgl[i]};
        det = ua && (m_h[i][SYNC] != m_h[i][SYNC+1]);
        go_idle = 0;
        m_vld[i] = 0; m_to[i] = 0; m_sp[i] = 0;
        if (!m_busy[i]) begin
            m_sp[i] = det;
            if (t_vld[i] && m_rdy[i]) begin
                m_data[i] = t_data[i]; m_vld[i] = 1; m_rdy[i] = 0;
                m_busy[i] = 1; m_ph[i] = 0; m_acked[i] = 0;
            end else begin
                m_rdy[i] = 1;
            end
        end else if (m_ph[i] < HOLD) begin
            if (det) m_acked[i] = 1;
            if (m_ph[i] == HOLD - 1 && !ua) go_idle = 1;
            else m_ph[i]++;
        end else begin
            if (det || m_acked[i]) go_idle = 1;
            else if (TMO > 0 && m_ph[i] - HOLD == TMO - 1) begin
                go_idle = 1; m_to[i] = 1;
            end else m_ph[i]++;
        end
        if (go_idle) begin
            m_busy[i] = 0; m_rdy[i] = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        to_cnt[0] = 0; to_cnt[1] = 0; sp_cnt[0] = 0; sp_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("rdy%0d", i),  64'(o_rdy[i]),  64'(m_rdy[i]));
                check($sformatf("vld%0d", i),  64'(o_vld[i]),  64'(m_vld[i]));
                check($sformatf("data%0d", i), 64'(o_data[i]), 64'(m_data[i]));
                check($sformatf("busy%0d", i), 64'(o_busy[i]), 64'(m_busy[i]));
                check($sformatf("tmo%0d", i),  64'(o_to[i]),   64'(m_to[i]));
                check($sformatf("spur%0d", i), 64'(o_sp[i]),   64'(m_sp[i]));
                if (o_to[i]) to_cnt[i]++;
                if (o_sp[i]) sp_cnt[i]++;
            end
        end
    end

    // kind 0: pulse, 1: idle, 2: timeout pulse
    function automatic logic sel(input int i, input int kind);
        case (kind)
            0:       return o_vld[i];
            1:       return !o_busy[i];
            default: return o_to[i];
        endcase
    endfunction

    task automatic wait_sig(input int i, input int kind, input int lim, output int at);
        int n;
        n = 0;
        while (!sel(i, kind) && n < lim) begin
            tick(1);
            n++;
        end
        check($sformatf("wait%0d_k%0d", i, kind), 64'(sel(i, kind)), 64'd1);
        at = cyc;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int p, p1, p2, tc, at, n0, n1;
        t_vld = '0; t_tgl = '0; t_data[0] = '0; t_data[1] = '0;
        rst_n = 1'b0;
        tick(3);
        check("rst_rdy", 64'(o_rdy), 64'd0);
        check("rst_flags", 64'({o_busy, o_vld, o_to, o_sp}), 64'd0);
        check("rst_data", 64'(o_data[1]), 64'd0);
        rst_n = 1'b1;
        tick(1);
        check("rel_rdy", 64'(o_rdy), 64'd3);
        check("rel_busy", 64'(o_busy), 64'd0);

        // USE_ACK=0: single word, then back-to-back
        t_data[0] = 39'h3456; t_vld[0] = 1'b1;
        tick(1);
        t_vld[0] = 1'b0; p = cyc;
        check("u0_pulse", 64'(o_vld[0]), 64'd1);
        check("u0_data", 64'(o_data[0]), 64'h3456);
        check("u0_rdy_low", 64'(o_rdy[0]), 64'd0);
        tick(1);
        check("u0_pulse_1cyc", 64'(o_vld[0]), 64'd0);
        tick(2);
        check("u0_data_held", 64'(o_data[0]), 64'h3456);
        tick(1);
        check("u0_rdy_back", 64'(cyc - p + 1) << 1 | 64'(o_rdy[0]), 64'd11);
        t_data[0] = 39'h0A0B; t_vld[0] = 1'b1;
        wait_sig(0, 0, 20, p1);
        tick(1);
        t_data[0] = 39'h0C0D;
        wait_sig(0, 0, 20, p2);
        t_vld[0] = 1'b0;
        check("u0_throughput", 64'(p2 - p1), 64'd5);
        check("u0_data2", 64'(o_data[0]), 64'h0C0D);
        tick(6);

        // USE_ACK=1: ack toggled 10 cycles after the pulse
        t_data[1] = 39'h1234; t_vld[1] = 1'b1;
        tick(1);
        t_vld[1] = 1'b0; p = cyc;
        check("u1_pulse", 64'(o_vld[1]), 64'd1);
        tick(10);
        t_tgl[1] = ~t_tgl[1]; tc = cyc;
        check("u1_waiting", 64'(o_busy[1]), 64'd1);
        wait_sig(1, 1, 20, at);
        check("u1_ack_lat", 64'(at - tc), 64'd3);
        check("u1_rdy_back", 64'(o_rdy[1]), 64'd1);
        check("u1_no_timeout", 64'(to_cnt[1]), 64'd0);
        tick(2);

        // ack during HOLD: latched, WAIT_ACK lasts one cycle
        t_data[1] = 39'h55AA; t_vld[1] = 1'b1;
        tick(1);
        t_vld[1] = 1'b0; p = cyc;
        tick(1);
        t_tgl[1] = ~t_tgl[1];
        wait_sig(1, 1, 20, at);
        check("u1_sticky_idle", 64'(at - p), 64'd5);
        tick(2);

        // no ack: timeout 64 cycles after entering WAIT_ACK (pulse+4)
        t_data[1] = 39'h40_0000_0001; t_vld[1] = 1'b1;
        tick(1);
        t_vld[1] = 1'b0; p = cyc; n0 = to_cnt[1];
        wait_sig(1, 2, 100, at);
        check("u1_to_time", 64'(at - p), 64'd68);
        check("u1_to_idle", 64'(o_busy[1]), 64'd0);
        check("u1_to_data", 64'(o_data[1]), 64'h40_0000_0001);
        tick(1);
        check("u1_to_once", 64'(to_cnt[1] - n0), 64'd1);
        tick(2);

        // ack detected on the expiry cycle: ack wins, no timeout pulse
        t_data[1] = 39'h6_6666; t_vld[1] = 1'b1;
        tick(1);
        t_vld[1] = 1'b0; p = cyc; n0 = to_cnt[1];
        tick(65);
        t_tgl[1] = ~t_tgl[1];
        wait_sig(1, 1, 20, at);
        check("u1_tie_time", 64'(at - p), 64'd68);
        tick(2);
        check("u1_tie_no_to", 64'(to_cnt[1] - n0), 64'd0);

        // toggles while IDLE
        n0 = sp_cnt[1]; n1 = sp_cnt[0];
        t_tgl = ~t_tgl;
        tick(6);
        check("u1_spurious", 64'(sp_cnt[1] - n0), 64'd1);
        check("u0_no_spurious", 64'(sp_cnt[0] - n1), 64'd0);
        check("u1_spur_idle", 64'(o_busy[1]), 64'd0);

        // reset during HOLD
        t_data[1] = 39'h1_2345; t_vld[1] = 1'b1;
        tick(1);
        t_vld[1] = 1'b0;
        tick(2);
        check("u1_in_hold", 64'(o_busy[1]), 64'd1);
        rst_n = 1'b0; t_tgl = '0;
        #1;
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        check("mid_rst_rdy", 64'(o_rdy), 64'd0);
        check("mid_rst_data", 64'(o_data[1]), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rerel_rdy", 64'(o_rdy[1]), 64'd1);
        t_data[1] = 39'h7F_FFFF_FFFF; t_vld[1] = 1'b1;
        tick(1);
        t_vld[1] = 1'b0;
        check("relaunch_pulse", 64'(o_vld[1]), 64'd1);
        check("relaunch_data", 64'(o_data[1]), 64'h7F_FFFF_FFFF);
        tick(5);
        t_tgl[1] = ~t_tgl[1];
        wait_sig(1, 1, 20, at);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux_tx.md
Name: dmux_tx

Overview:
- Source-side launcher for the DMUX crossing.
- Takes words from an upstream valid/ready stream and presents each on data_out with a single-cycle data_out_vld pulse.
- Holds data_out stable for a guaranteed window so the destination-side DMUX can sample it safely.
- Optionally waits for a toggle-style acknowledge returned from the destination domain before accepting the next word.

Parameters:
- DATA_WIDTH, 39, word width; matches the DMUX data_in width.
- HOLD_CYCLES, 4, minimum clk_i cycles data_out is stable, counting the pulse cycle; legal range 1..255.
- SYNC_STAGES, 2, flop stages on the asynchronous dst_ack_tgl input; legal range 2..4.
- USE_ACK, 1, 1 = wait for ack toggle before next accept; 0 = free-running on the hold window only.
- TIMEOUT_CYCLES, 64, ack wait limit in cycles; 0 disables the timeout.

Ports:
- clk_i, input, 1, single clock.
- reset_n, input, 1, asynchronous active-low reset.
- src_data, input, DATA_WIDTH, upstream word.
- src_vld, input, 1, upstream valid.
- src_rdy, output, 1, registered ready to upstream.
- data_out, output, DATA_WIDTH, held word toward DMUX data_in.
- data_out_vld, output, 1, one-cycle launch pulse toward DMUX data_in_vld.
- dst_ack_tgl, input, 1, asynchronous toggle; destination flips it once per received word.
- busy, output, 1, high in any state other than IDLE.
- ack_timeout, output, 1, one-cycle pulse when the ack wait expires.
- spurious_ack, output, 1, one-cycle pulse on an ack edge while IDLE.

Behaviour:
- Reset values (async, reset_n low): state IDLE, src_rdy 0, data_out 0, data_out_vld 0, busy 0, ack_timeout 0, spurious_ack 0, hold/timeout counters 0, ack sync chain and previous-ack flop 0.
- First rising edge after reset release sets src_rdy to 1.
- The destination's toggle must also reset to 0.
- FSM states: IDLE, LAUNCH, HOLD, WAIT_ACK.
- IDLE:
  - src_rdy=1.
  - On an edge with src_vld&&src_rdy: data_out<=src_data, data_out_vld<=1, src_rdy<=0, go to LAUNCH.
  - Latency is 1 cycle from accept edge to pulse.
- LAUNCH: lasts exactly one cycle with data_out_vld=1.
  - Next state is HOLD if HOLD_CYCLES>1.
  - Otherwise WAIT_ACK if USE_ACK=1, otherwise IDLE.
- HOLD:
  - data_out_vld=0 and data_out unchanged.
  - Stays HOLD_CYCLES-1 cycles, then goes to WAIT_ACK if USE_ACK=1, otherwise IDLE.
- WAIT_ACK:
  - Leaves on a detected ack edge, going to IDLE.
  - If TIMEOUT_CYCLES>0, after TIMEOUT_CYCLES cycles in WAIT_ACK it pulses ack_timeout and goes to IDLE.
  - If ack edge and timeout expiry coincide, the ack wins and there is no timeout pulse.
- Ack edge detection:
  - Edge = synchronized dst_ack_tgl differs from its previous registered value.
  - Detection latency is SYNC_STAGES+1 cycles from the input toggle.
- An ack edge detected during LAUNCH or HOLD is latched in a sticky flag.
  - The flag is consumed on entry to WAIT_ACK, which exits to IDLE after exactly 1 cycle.
- An ack edge detected in IDLE produces a spurious_ack pulse and has no other effect.
- With USE_ACK=0, ack edges are ignored entirely and spurious_ack is never asserted.
- data_out is never cleared outside reset; it retains the last launched word.
- src_rdy is low in LAUNCH, HOLD and WAIT_ACK.
- Peak throughput with USE_ACK=0 is one word per HOLD_CYCLES+1 cycles.
- Reset mid-operation aborts immediately to reset values; the in-flight word is discarded.
- The hold counter uses 8 bits. The timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Package dmux_pkg:
  - dmux_tx_state_e enum (IDLE, LAUNCH, HOLD, WAIT_ACK).
  - Localparams DMUX_DATA_WIDTH_DEF=39 and DMUX_SYNC_STAGES_DEF=2.
- Sub-module dmux_ack_sync:
  - Contains the SYNC_STAGES flop chain and previous-value flop.
  - Outputs a one-cycle ack_edge.
  - Uses the same clk_i and reset_n.

Test Plan:
- Reset then release, src_vld=0: all outputs 0 during reset; src_rdy=1 one cycle after release; busy=0.
- USE_ACK=0, HOLD_CYCLES=4, src_data=39'h3456, src_vld for one accept: data_out_vld high for exactly 1 cycle one cycle after accept; data_out=39'h3456 stable for 4 cycles; src_rdy back at cycle 5. With src_vld held continuously, the next pulse arrives 5 cycles after the first.
- USE_ACK=1, word 39'h1234, toggle dst_ack_tgl 10 cycles after the pulse: stays in WAIT_ACK; returns to IDLE SYNC_STAGES+1 cycles after the toggle; src_rdy=1 the cycle after; no ack_timeout.
- USE_ACK=1, toggle ack during HOLD: sticky flag captured; WAIT_ACK lasts 1 cycle; IDLE reached at pulse+HOLD_CYCLES+1.
- TIMEOUT_CYCLES=64, no ack: ack_timeout pulses once exactly 64 cycles after entering WAIT_ACK; returns to IDLE; data_out keeps its value. A toggle arriving on the expiry cycle gives no timeout pulse.
- Toggle ack while IDLE → single spurious_ack pulse. Assert reset_n low during HOLD → outputs 0 immediately; after release, a new word 39'h7F_FFFF_FFFF launches normally.
